// File: rtl/shift_add_mult.sv
`default_nettype none
// ============================================================================
//  Module   : shift_add_mult
//  Purpose  : Sequential shift-and-add multiplier. One multiplier bit is
//             consumed per clock, LSB first, giving a fixed latency of N
//             cycles. Optional two's-complement operands (sign-magnitude
//             internally), optional auto-launch on operand change, and an
//             optionally inverted LED copy of the product.
//  Ports    : clk   - clock, rising edge
//             rst   - asynchronous active-high reset
//             start - launch request (AUTO=0 only)
//             a, b  - multiplicand / multiplier, N bits
//             busy  - operation in progress (N cycles)
//             done  - one-cycle pulse, new product on p
//             p     - registered 2N-bit product of the last operation
//             led   - p, or ~p when INV=1
//  Revision : 1.0 - initial release
// ============================================================================
module shift_add_mult #(
  parameter int N      = 8,
  parameter int SIGNED = 0,
  parameter int AUTO   = 0,
  parameter int INV    = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] p,
  output logic [2*N-1:0] led
);

  localparam int         CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   mcand_q, mcand_d;
  logic [N-1:0]     mplier_q, mplier_d;
  logic [2*N-1:0]   acc_q, acc_d;
  logic             neg_q, neg_d;
  logic [2*N-1:0]   p_q, p_d;
  logic             done_q, done_d;
  logic [2*N-1:0]   prev_q, prev_d;
  logic             pend_q, pend_d;

  logic             launch;
  logic             opnd_changed;
  logic [N-1:0]     a_mag;
  logic [N-1:0]     b_mag;
  logic [2*N-1:0]   addend;
  logic [2*N-1:0]   acc_sum;

  // The operand copy follows {a,b} every cycle. A change seen while RUN is
  // remembered in pend so that the operation is relaunched once the current
  // one completes, even though the copy has already caught up by then.
  assign opnd_changed = (prev_q != {a, b});

  always_comb begin
    launch = 1'b0;
    if (state_q == IDLE) begin
      if (AUTO != 0) launch = opnd_changed || pend_q;
      else           launch = start;
    end
  end

  // Magnitudes: -2^(N-1) negates to itself, which read unsigned is exactly
  // 2^(N-1), so no extra bit is needed.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (SIGNED != 0) begin
      if (a[N-1]) a_mag = -a;
      if (b[N-1]) b_mag = -b;
    end
  end

  assign addend  = mplier_q[0] ? mcand_q : '0;
  assign acc_sum = acc_q + addend;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    p_d      = p_q;
    done_d   = 1'b0;
    prev_d   = {a, b};
    pend_d   = pend_q;

    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d  = RUN;
          cnt_d    = '0;
          mcand_d  = {{N{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          neg_d    = (SIGNED != 0) ? (a[N-1] ^ b[N-1]) : 1'b0;
          pend_d   = 1'b0;
        end
      end
      RUN: begin
        if ((AUTO != 0) && opnd_changed) pend_d = 1'b1;
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == LAST) begin
          // Last bit: the sum including this bit is the final magnitude.
          p_d     = neg_q ? -acc_sum : acc_sum;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
      done_q   <= 1'b0;
      prev_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
      done_q   <= done_d;
      prev_q   <= prev_d;
      pend_q   <= pend_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign p    = p_q;

  generate
    if (INV != 0) begin : g_led_inv
      assign led = ~p_q;
    end else begin : g_led_true
      assign led = p_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_add_mult
//  Purpose  : Directed self-checking bench for shift_add_mult (N=8) with four
//             instances: unsigned, signed, auto-launch and inverted-LED.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // unsigned, start-launched
  logic        start_u = 1'b0;
  logic [7:0]  a_u = '0, b_u = '0;
  logic        busy_u, done_u;
  logic [15:0] p_u, led_u;
  // signed
  logic        start_s = 1'b0;
  logic [7:0]  a_s = '0, b_s = '0;
  logic        busy_s, done_s;
  logic [15:0] p_s, led_s;
  // auto-launch
  logic        start_a = 1'b0;
  logic [7:0]  a_a = 8'd10, b_a = 8'd3;
  logic        busy_a, done_a;
  logic [15:0] p_a, led_a;
  // inverted LED
  logic        start_i = 1'b0;
  logic [7:0]  a_i = '0, b_i = '0;
  logic        busy_i, done_i;
  logic [15:0] p_i, led_i;

  shift_add_mult #(.N(8), .SIGNED(0), .AUTO(0), .INV(0)) u_uns (
    .clk(clk), .rst(rst), .start(start_u), .a(a_u), .b(b_u),
    .busy(busy_u), .done(done_u), .p(p_u), .led(led_u));
  shift_add_mult #(.N(8), .SIGNED(1), .AUTO(0), .INV(0)) u_sgn (
    .clk(clk), .rst(rst), .start(start_s), .a(a_s), .b(b_s),
    .busy(busy_s), .done(done_s), .p(p_s), .led(led_s));
  shift_add_mult #(.N(8), .SIGNED(0), .AUTO(1), .INV(0)) u_auto (
    .clk(clk), .rst(rst), .start(start_a), .a(a_a), .b(b_a),
    .busy(busy_a), .done(done_a), .p(p_a), .led(led_a));
  shift_add_mult #(.N(8), .SIGNED(0), .AUTO(0), .INV(1)) u_inv (
    .clk(clk), .rst(rst), .start(start_i), .a(a_i), .b(b_i),
    .busy(busy_i), .done(done_i), .p(p_i), .led(led_i));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bc;
    int dc;

    // ---------------- reset state ----------------
    tick();
    check_val("rst_p",     32'(p_u),    32'h0);
    check_val("rst_busy",  32'(busy_u), 32'h0);
    check_val("rst_done",  32'(done_u), 32'h0);
    check_val("rst_led_i", 32'(led_i),  32'hFFFF);
    check_val("rst_led_u", 32'(led_u),  32'h0);
    rst = 1'b0;
    tick();
    // auto instance sees {10,3} against the cleared copy and launches
    check_val("auto_first_edge_busy", 32'(busy_a), 32'h1);
    check_val("uns_idle_busy",        32'(busy_u), 32'h0);

    // ---------------- 255 * 255 unsigned ----------------
    a_u = 8'd255; b_u = 8'd255; start_u = 1'b1;
    tick();
    start_u = 1'b0;
    bc = 0;
    while (busy_u && bc < 20) begin
      bc++;
      tick();
    end
    check_val("ff_busy_cycles", 32'(bc),     32'd8);
    check_val("ff_done",        32'(done_u), 32'h1);
    check_val("ff_p",           32'(p_u),    32'hFE01);
    check_val("ff_led",         32'(led_u),  32'hFE01);
    tick();
    check_val("ff_done_pulse_end", 32'(done_u), 32'h0);
    check_val("ff_p_hold",         32'(p_u),    32'hFE01);
    check_val("auto_first_p",      32'(p_a),    32'd30);

    // ---------------- start held high: 7 * 6 ----------------
    a_u = 8'd7; b_u = 8'd6; start_u = 1'b1;
    tick();
    check_val("hold_p_not_cleared", 32'(p_u),    32'hFE01);
    check_val("hold_busy",          32'(busy_u), 32'h1);
    repeat (3) tick();
    check_val("hold_mid_done", 32'(done_u), 32'h0);
    repeat (5) tick();
    check_val("hold_done1", 32'(done_u), 32'h1);
    check_val("hold_p1",    32'(p_u),    32'd42);
    tick();
    check_val("hold_relaunch_busy", 32'(busy_u), 32'h1);
    check_val("hold_relaunch_done", 32'(done_u), 32'h0);
    repeat (7) tick();
    check_val("hold_early_done", 32'(done_u), 32'h0);
    tick();
    check_val("hold_done2", 32'(done_u), 32'h1);
    check_val("hold_p2",    32'(p_u),    32'd42);
    start_u = 1'b0;
    tick();
    check_val("hold_stop_busy", 32'(busy_u), 32'h0);

    // ---------------- signed ----------------
    a_s = 8'hFD; b_s = 8'd5; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    repeat (8) tick();
    check_val("sgn_done1", 32'(done_s), 32'h1);
    check_val("sgn_m3x5",  32'(p_s),    32'hFFF1);
    // launch in the done cycle: back-to-back
    a_s = 8'h80; b_s = 8'h80; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    check_val("sgn_b2b_busy", 32'(busy_s), 32'h1);
    repeat (8) tick();
    check_val("sgn_m128sq", 32'(p_s), 32'h4000);
    a_s = 8'h80; b_s = 8'h7F; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    repeat (8) tick();
    check_val("sgn_m128x127", 32'(p_s), 32'hC080);
    a_s = 8'hF9; b_s = 8'hFA; start_s = 1'b1;   // -7 * -6
    tick();
    start_s = 1'b0;
    repeat (8) tick();
    check_val("sgn_m7xm6", 32'(p_s), 32'd42);

    // ---------------- auto launch ----------------
    b_a = 8'd4;
    tick();
    check_val("auto_launch_busy", 32'(busy_a), 32'h1);
    repeat (8) tick();
    check_val("auto_done", 32'(done_a), 32'h1);
    check_val("auto_p40",  32'(p_a),    32'd40);
    tick();
    check_val("auto_single_busy", 32'(busy_a), 32'h0);
    tick();
    check_val("auto_single_busy2", 32'(busy_a), 32'h0);
    b_a = 8'd5;
    tick();                      // launch edge k (10*5)
    repeat (2) tick();
    b_a = 8'd6;                  // change during RUN
    repeat (6) tick();           // edge k+8
    check_val("auto_mid_done1", 32'(done_a), 32'h1);
    check_val("auto_mid_p50",   32'(p_a),    32'd50);
    tick();
    check_val("auto_relaunch_busy", 32'(busy_a), 32'h1);
    repeat (8) tick();
    check_val("auto_mid_done2", 32'(done_a), 32'h1);
    check_val("auto_mid_p60",   32'(p_a),    32'd60);
    tick();
    check_val("auto_mid_idle", 32'(busy_a), 32'h0);

    // ---------------- inverted LED ----------------
    a_i = 8'd2; b_i = 8'd3; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (8) tick();
    check_val("inv_p",   32'(p_i),   32'd6);
    check_val("inv_led", 32'(led_i), 32'hFFF9);

    // ---------------- reset mid-RUN ----------------
    a_u = 8'd9; b_u = 8'd9; start_u = 1'b1;
    tick();
    start_u = 1'b0;
    repeat (4) tick();
    check_val("rstmid_busy_before", 32'(busy_u), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_val("rstmid_p_async",    32'(p_u),    32'h0);
    check_val("rstmid_busy_async", 32'(busy_u), 32'h0);
    check_val("rstmid_led_inv",    32'(led_i),  32'hFFFF);
    tick();
    rst = 1'b0;
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done_u) dc++;
    end
    check_val("rstmid_no_done", 32'(dc),  32'd0);
    check_val("rstmid_p_stays", 32'(p_u), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
